avc_scan_seq: RTL and testbench

Top-level sequencer for AVC file access on the SD DAT line. It issues directory sector reads starting at the root directory and enables the AVC file-finder during each directory packet. It evaluates the finder's found/null flags after every packet. Once the AVC file is found, it streams the file's sectors to the vector parser under consumer backpressure.

---
 rtl/avc_scan_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_avc_scan_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avc_scan_seq.sv
// AVC file access sequencer: walks directory sectors from the root until the
// file-finder reports the AVC entry, then streams the file's sectors to the parser.
module avc_scan_seq #(
   parameter int MAXDIRSEC = 32,
   parameter int TOUT      = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] ROOTSEC,
   input  logic [15:0] AVCFSEC,
   input  logic [15:0] NSEC,
   input  logic        fnmnull,
   input  logic        avcff,
   input  logic        rdack,
   input  logic        tcvdptdone,
   input  logic        snkrdy,
   output logic        rdreq,
   output logic [31:0] RDADDR,
   output logic        avcrfen,
   output logic        avcfen,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  ERRCODE,
   output logic [15:0] SECCNT
);

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_DIRREQ   = 4'd1;
   localparam logic [3:0] ST_DIRWAIT  = 4'd2;
   localparam logic [3:0] ST_DIRCHK   = 4'd3;
   localparam logic [3:0] ST_FILEREQ  = 4'd4;
   localparam logic [3:0] ST_FILEWAIT = 4'd5;
   localparam logic [3:0] ST_FILECHK  = 4'd6;
   localparam logic [3:0] ST_DONE     = 4'd7;
   localparam logic [3:0] ST_ERR      = 4'd8;

   localparam logic [1:0] EC_NONE     = 2'd0;
   localparam logic [1:0] EC_NOTFOUND = 2'd1;
   localparam logic [1:0] EC_DIREXH   = 2'd2;
   localparam logic [1:0] EC_TIMEOUT  = 2'd3;

   localparam logic [31:0] LAST_DIRSEC = 32'(MAXDIRSEC - 1);
   localparam logic [15:0] TOUT_LIM    = 16'(TOUT);

   logic [3:0]  state_r, state_s;
   logic [31:0] dirsec_r, dirsec_s;
   logic [15:0] fcnt_r, fcnt_s;
   logic [15:0] fbase_r, fbase_s;
   logic [15:0] tocnt_r, tocnt_s;
   logic [15:0] seccnt_r, seccnt_s;
   logic [1:0]  errcode_r, errcode_s;
   logic [31:0] rdaddr_r;
   logic        dir_req_r;
   logic        file_req_r;
   logic        avcrfen_r;
   logic        avcfen_r;
   logic        busy_r;
   logic        done_r;
   logic        err_r;
   logic        count_en_s;
   logic        timeout_s;

   assign timeout_s = (tocnt_r == TOUT_LIM);

   // Next-state and counter update decisions; abort overrides every state.
   always_comb begin
      state_s    = state_r;
      dirsec_s   = dirsec_r;
      fcnt_s     = fcnt_r;
      fbase_s    = fbase_r;
      seccnt_s   = seccnt_r;
      errcode_s  = errcode_r;
      count_en_s = 1'b0;
      if (abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_s   = ST_DIRREQ;
                  dirsec_s  = 32'd0;
                  fcnt_s    = 16'd0;
                  seccnt_s  = 16'd0;
                  errcode_s = EC_NONE;
               end else begin
                  state_s = state_r;
               end
            end
            ST_DIRREQ: begin
               count_en_s = 1'b1;
               if (timeout_s) begin
                  state_s   = ST_ERR;
                  errcode_s = EC_TIMEOUT;
               end else if (rdack) begin
                  state_s = ST_DIRWAIT;
               end else begin
                  state_s = ST_DIRREQ;
               end
            end
            ST_DIRWAIT: begin
               count_en_s = 1'b1;
               if (timeout_s) begin
                  state_s   = ST_ERR;
                  errcode_s = EC_TIMEOUT;
               end else if (tcvdptdone) begin
                  state_s = ST_DIRCHK;
               end else begin
                  state_s = ST_DIRWAIT;
               end
            end
            ST_DIRCHK: begin
               if (fnmnull) begin
                  state_s   = ST_ERR;
                  errcode_s = EC_NOTFOUND;
               end else if (avcff) begin
                  fbase_s = AVCFSEC;
                  if (NSEC == 16'd0) begin
                     state_s = ST_DONE;
                  end else begin
                     state_s = ST_FILEREQ;
                  end
               end else if (dirsec_r == LAST_DIRSEC) begin
                  state_s   = ST_ERR;
                  errcode_s = EC_DIREXH;
               end else begin
                  dirsec_s = dirsec_r + 32'd1;
                  state_s  = ST_DIRREQ;
               end
            end
            // A stalled consumer is legal, so the timer only runs while the request is visible.
            ST_FILEREQ: begin
               if (snkrdy) begin
                  count_en_s = 1'b1;
                  if (timeout_s) begin
                     state_s   = ST_ERR;
                     errcode_s = EC_TIMEOUT;
                  end else if (rdack) begin
                     state_s = ST_FILEWAIT;
                  end else begin
                     state_s = ST_FILEREQ;
                  end
               end else begin
                  state_s = ST_FILEREQ;
               end
            end
            ST_FILEWAIT: begin
               count_en_s = 1'b1;
               if (timeout_s) begin
                  state_s   = ST_ERR;
                  errcode_s = EC_TIMEOUT;
               end else if (tcvdptdone) begin
                  state_s = ST_FILECHK;
               end else begin
                  state_s = ST_FILEWAIT;
               end
            end
            ST_FILECHK: begin
               fcnt_s   = fcnt_r + 16'd1;
               seccnt_s = fcnt_r + 16'd1;
               if (fcnt_s == NSEC) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FILEREQ;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Wait-state timer: restarts on every state change, advances only in counting states.
   always_comb begin
      tocnt_s = tocnt_r;
      if (state_s != state_r) begin
         tocnt_s = 16'd0;
      end else if (count_en_s) begin
         tocnt_s = tocnt_r + 16'd1;
      end else begin
         tocnt_s = tocnt_r;
      end
   end

   // State, counters and outputs, all registered from the next-state decision.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         dirsec_r   <= 32'd0;
         fcnt_r     <= 16'd0;
         fbase_r    <= 16'd0;
         tocnt_r    <= 16'd0;
         seccnt_r   <= 16'd0;
         errcode_r  <= EC_NONE;
         rdaddr_r   <= 32'd0;
         dir_req_r  <= 1'b0;
         file_req_r <= 1'b0;
         avcrfen_r  <= 1'b0;
         avcfen_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r   <= state_s;
         dirsec_r  <= dirsec_s;
         fcnt_r    <= fcnt_s;
         fbase_r   <= fbase_s;
         tocnt_r   <= tocnt_s;
         seccnt_r  <= seccnt_s;
         errcode_r <= errcode_s;
         // Address is captured on entry to a request state and held until it is accepted.
         if ((state_s == ST_DIRREQ) && (state_r != ST_DIRREQ)) begin
            rdaddr_r <= ROOTSEC + dirsec_s;
         end else if ((state_s == ST_FILEREQ) && (state_r != ST_FILEREQ)) begin
            rdaddr_r <= {16'd0, fbase_s} + {16'd0, fcnt_s};
         end else begin
            rdaddr_r <= rdaddr_r;
         end
         dir_req_r  <= (state_s == ST_DIRREQ);
         file_req_r <= (state_s == ST_FILEREQ);
         avcrfen_r  <= (state_s == ST_DIRWAIT);
         avcfen_r   <= (state_s == ST_FILEWAIT);
         busy_r     <= (state_s != ST_IDLE) && (state_s != ST_DONE) && (state_s != ST_ERR);
         done_r     <= (state_s == ST_DONE) && (state_r != ST_DONE);
         err_r      <= (state_s == ST_ERR);
      end
   end

   // File requests must follow snkrdy in the same cycle, hence the one gate after the register.
   assign rdreq   = dir_req_r | (file_req_r & snkrdy);
   assign RDADDR  = rdaddr_r;
   assign avcrfen = avcrfen_r;
   assign avcfen  = avcfen_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;
   assign ERRCODE = errcode_r;
   assign SECCNT  = seccnt_r;

endmodule

// File: tb/tb_avc_scan_seq.sv
// Self-checking bench for avc_scan_seq: scenario table, hand-written corner
// sequences and randomized scenarios scored against a transaction-level model.
module tb_avc_scan_seq;

   localparam int MAXD = 4;
   localparam int TOUT = 16;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [31:0] ROOTSEC;
   logic [15:0] AVCFSEC, NSEC;
   logic        fnmnull, avcff, rdack, tcvdptdone, snkrdy;
   logic        rdreq, avcrfen, avcfen, busy, done, err;
   logic [31:0] RDADDR;
   logic [1:0]  ERRCODE;
   logic [15:0] SECCNT;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] root;
      logic [15:0] fsec;
      logic [15:0] nsec;
      int          tgt;      // directory packet (1-based) carrying the finder flag
      bit          is_null;  // flag is fnmnull rather than avcff
      int          snk;      // 0: consumer always ready, 1: random stalls
      logic [1:0]  ecode;
      logic [15:0] esec;
      int          ereads;
      int          edone;
   } vec_t;

   avc_scan_seq #(.MAXDIRSEC(MAXD), .TOUT(TOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .ROOTSEC(ROOTSEC), .AVCFSEC(AVCFSEC), .NSEC(NSEC),
      .fnmnull(fnmnull), .avcff(avcff), .rdack(rdack),
      .tcvdptdone(tcvdptdone), .snkrdy(snkrdy),
      .rdreq(rdreq), .RDADDR(RDADDR), .avcrfen(avcrfen), .avcfen(avcfen),
      .busy(busy), .done(done), .err(err), .ERRCODE(ERRCODE), .SECCNT(SECCNT)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Outcome of a scenario from the rules: flag position versus directory size.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit   found;
      int   ndir;
      r      = v;
      ndir   = (v.tgt <= MAXD) ? v.tgt : MAXD;
      found  = (v.tgt <= MAXD) && !v.is_null;
      r.ecode  = (v.tgt > MAXD) ? 2'd2 : (v.is_null ? 2'd1 : 2'd0);
      r.esec   = found ? v.nsec : 16'd0;
      r.ereads = ndir + (found ? int'(v.nsec) : 0);
      r.edone  = found ? 1 : 0;
      return r;
   endfunction

   task automatic run_scen(input string name, input vec_t v);
      logic [31:0] expq[$];
      int  ndir, naccept, pkt, ackd, viol, dpulse, budget;
      bit  found, fin;
      ndir    = (v.tgt <= MAXD) ? v.tgt : MAXD;
      found   = (v.tgt <= MAXD) && !v.is_null;
      naccept = 0; pkt = 0; ackd = 0; viol = 0; dpulse = 0; budget = 0; fin = 1'b0;
      for (int i = 0; i < ndir; i++) expq.push_back(v.root + 32'(i));
      if (found) for (int j = 0; j < int'(v.nsec); j++) expq.push_back({16'd0, v.fsec} + 32'(j));
      ROOTSEC = v.root; AVCFSEC = v.fsec; NSEC = v.nsec;
      fnmnull = 1'b0; avcff = 1'b0; rdack = 1'b0; tcvdptdone = 1'b0; snkrdy = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      while (!fin && budget < 3000) begin
         if (avcrfen && avcfen) viol++;
         if (err && (avcrfen || avcfen)) viol++;
         if (!found && avcfen) viol++;
         if (done) dpulse++;
         if (done || err) fin = 1'b1;
         tcvdptdone = 1'b0;
         rdack      = 1'b0;
         snkrdy     = (v.snk == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (pkt > 0) begin
            pkt--;
            if (pkt == 0) begin
               tcvdptdone = 1'b1;
               if (naccept <= ndir) begin
                  if (!avcrfen || avcfen) viol++;
               end else begin
                  if (!avcfen || avcrfen) viol++;
               end
            end
         end else if (ackd > 0) begin
            ackd--;
         end else begin
            rdack = 1'b1;
         end
         #1;
         if (rdreq && !snkrdy && naccept >= ndir) viol++;
         if (rdreq && rdack) begin
            if (naccept < expq.size())
               check($sformatf("%s rdaddr[%0d]", name, naccept), RDADDR, expq[naccept]);
            naccept++;
            pkt  = $urandom_range(1, 8);
            ackd = $urandom_range(0, 4);
            if (naccept == v.tgt) begin
               fnmnull = v.is_null;
               avcff   = !v.is_null;
            end
         end
         cyc();
         budget++;
      end
      rdack = 1'b0; tcvdptdone = 1'b0; snkrdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (done) dpulse++;
         cyc();
      end
      check({name, " finished"}, 32'(fin), 32'd1);
      check({name, " reads"}, 32'(naccept), 32'(v.ereads));
      check({name, " errcode"}, 32'(ERRCODE), 32'(v.ecode));
      check({name, " err"}, 32'(err), (v.ecode != 2'd0) ? 32'd1 : 32'd0);
      check({name, " seccnt"}, 32'(SECCNT), 32'(v.esec));
      check({name, " done pulses"}, 32'(dpulse), 32'(v.edone));
      check({name, " busy"}, 32'(busy), 32'd0);
      check({name, " invariants"}, 32'(viol), 32'd0);
   endtask

   // One directed read: wait for the request, accept it, deliver the packet, leave CHK.
   task automatic hs_xfer(input string name, input logic fnull, input logic ff, input logic [31:0] exp_addr);
      int n;
      n = 0;
      #1;
      while (!rdreq && n < 40) begin
         cyc();
         n++;
      end
      check({name, " req"}, 32'(rdreq), 32'd1);
      check({name, " addr"}, RDADDR, exp_addr);
      rdack = 1'b1;
      cyc();
      rdack = 1'b0;
      tcvdptdone = 1'b1; fnmnull = fnull; avcff = ff;
      cyc();
      tcvdptdone = 1'b0;
      cyc();
      fnmnull = 1'b0; avcff = 1'b0;
   endtask

   initial begin
      vec_t tbl[6];
      vec_t rv;
      int   n, bad;

      tbl[0] = '{32'h100, 16'h40, 16'd3, 3, 1'b0, 0, 2'd0, 16'd3, 6, 1};
      tbl[1] = '{32'h100, 16'h40, 16'd3, 1, 1'b1, 0, 2'd1, 16'd0, 1, 0};
      tbl[2] = '{32'h100, 16'h40, 16'd3, 99, 1'b0, 0, 2'd2, 16'd0, 4, 0};
      tbl[3] = '{32'hFFFF_FFFE, 16'hFFFF, 16'd2, 4, 1'b0, 1, 2'd0, 16'd2, 6, 1};
      tbl[4] = '{32'h7, 16'h9, 16'd0, 1, 1'b0, 1, 2'd0, 16'd0, 1, 1};
      tbl[5] = '{32'h20, 16'h9, 16'd2, 4, 1'b1, 0, 2'd1, 16'd0, 4, 0};

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      ROOTSEC = 32'd0; AVCFSEC = 16'd0; NSEC = 16'd0;
      fnmnull = 1'b0; avcff = 1'b0; rdack = 1'b0; tcvdptdone = 1'b0; snkrdy = 1'b1;
      cyc(); cyc(); cyc();
      check("reset flags", 32'({rdreq, avcrfen, avcfen, busy, done, err}), 32'd0);
      check("reset rdaddr", RDADDR, 32'd0);
      check("reset errcode", 32'(ERRCODE), 32'd0);
      check("reset seccnt", 32'(SECCNT), 32'd0);
      reset = 1'b0;
      cyc();
      check("idle busy", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) run_scen($sformatf("tbl%0d", i), tbl[i]);

      // Timeout in DIRWAIT, with a start pulse while busy that must be ignored.
      ROOTSEC = 32'h200; NSEC = 16'd1;
      start = 1'b1; cyc(); start = 1'b0;
      check("to first req", 32'(rdreq), 32'd1);
      check("to first addr", RDADDR, 32'h200);
      check("to busy", 32'(busy), 32'd1);
      cyc(); cyc();
      check("to req held", 32'({rdreq, RDADDR}), {1'b1, 32'h200});
      rdack = 1'b1; cyc(); rdack = 1'b0;
      check("to dirwait", 32'({rdreq, avcrfen}), 32'd1);
      n = 0;
      while (avcrfen && n < 100) begin
         start = (n == 3);
         n++;
         cyc();
      end
      start = 1'b0;
      // tocnt hits TOUT during the (TOUT+1)-th DIRWAIT cycle, which then moves to ERR.
      check("to wait cycles", 32'(n), 32'(TOUT + 1));
      check("to err", 32'(err), 32'd1);
      check("to errcode", 32'(ERRCODE), 32'd3);
      start = 1'b1; cyc(); start = 1'b0;
      check("err restart", 32'({err, rdreq, ERRCODE}), 32'b0100);
      abort = 1'b1; cyc(); abort = 1'b0;
      check("abort dirreq", 32'({busy, rdreq}), 32'd0);

      // Abort during FILEWAIT keeps SECCNT and drops every enable.
      ROOTSEC = 32'h300; AVCFSEC = 16'h80; NSEC = 16'd3;
      start = 1'b1; cyc(); start = 1'b0;
      hs_xfer("ab dir", 1'b0, 1'b1, 32'h300);
      hs_xfer("ab f0", 1'b0, 1'b0, 32'h80);
      check("ab seccnt1", 32'(SECCNT), 32'd1);
      check("ab f1 addr", RDADDR, 32'h81);
      rdack = 1'b1; cyc(); rdack = 1'b0;
      check("ab filewait", 32'(avcfen), 32'd1);
      abort = 1'b1; cyc(); abort = 1'b0;
      check("ab outputs", 32'({busy, rdreq, avcrfen, avcfen, err, done}), 32'd0);
      check("ab seccnt kept", 32'(SECCNT), 32'd1);
      tcvdptdone = 1'b1; cyc(); tcvdptdone = 1'b0;
      check("ab stray pkt", 32'(busy), 32'd0);

      // Consumer stall of 50 cycles between file sectors.
      ROOTSEC = 32'h400; AVCFSEC = 16'h1234; NSEC = 16'd2;
      start = 1'b1; cyc(); start = 1'b0;
      hs_xfer("bp dir", 1'b0, 1'b1, 32'h400);
      hs_xfer("bp f0", 1'b0, 1'b0, 32'h1234);
      snkrdy = 1'b0;
      #1;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         if (rdreq || err || !busy) bad++;
         cyc();
      end
      check("bp stall", 32'(bad), 32'd0);
      snkrdy = 1'b1;
      #1;
      check("bp resume", 32'({rdreq, RDADDR}), {1'b1, 32'h1235});
      hs_xfer("bp f1", 1'b0, 1'b0, 32'h1235);
      check("bp done", 32'({done, busy, err}), 32'b100);
      check("bp seccnt", 32'(SECCNT), 32'd2);
      cyc();
      check("bp done pulse", 32'(done), 32'd0);

      // Reset mid-file, then a zero-length file goes straight to DONE.
      ROOTSEC = 32'h500; AVCFSEC = 16'h10; NSEC = 16'd3;
      start = 1'b1; cyc(); start = 1'b0;
      hs_xfer("rs dir", 1'b0, 1'b1, 32'h500);
      hs_xfer("rs f0", 1'b0, 1'b0, 32'h10);
      rdack = 1'b1; cyc(); rdack = 1'b0;
      reset = 1'b1; abort = 1'b1; cyc(); reset = 1'b0; abort = 1'b0;
      check("rs flags", 32'({rdreq, avcrfen, avcfen, busy, done, err}), 32'd0);
      check("rs regs", {RDADDR[15:0], SECCNT}, 32'd0);
      check("rs errcode", 32'(ERRCODE), 32'd0);
      NSEC = 16'd0;
      start = 1'b1; cyc(); start = 1'b0;
      hs_xfer("rs0 dir", 1'b0, 1'b1, 32'h500);
      check("rs0 done", 32'({done, busy, SECCNT}), {1'b1, 1'b0, 16'd0});
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (rdreq || avcfen) bad++;
         cyc();
      end
      check("rs0 no file", 32'(bad), 32'd0);

      for (int i = 0; i < 25; i++) begin
         rv.root    = $urandom;
         rv.fsec    = 16'($urandom_range(0, 65535));
         rv.nsec    = 16'($urandom_range(0, 5));
         rv.tgt     = $urandom_range(1, MAXD + 2);
         rv.is_null = ($urandom_range(0, 1) == 1);
         rv.snk     = 1;
         rv         = model(rv);
         run_scen($sformatf("rnd%0d", i), rv);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
